// File: rtl/throw_pkg.sv
// throw_pkg: shared states, player ids and helpers for the cat-vs-dog throw datapath.
package throw_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AIM,
    ST_CHARGE,
    ST_FLIGHT,
    ST_RESOLVE,
    ST_GAP,
    ST_OVER
  } turn_state_t;
  localparam logic PLAYER_CAT = 1'b0;
  localparam logic PLAYER_DOG = 1'b1;
  localparam logic [6:0] WIND_CALM = 7'd50;
  function automatic logic [6:0] sat_sub(input logic [6:0] a, input logic [6:0] b);
    return a > b ? a - b : 7'd0;
  endfunction
  function automatic logic [6:0] wind_mod101(input logic [6:0] v);
    return v >= 7'd101 ? v - 7'd101 : v;
  endfunction
endpackage

// File: rtl/tick_gen.sv
// tick_gen: free-running prescaler emitting a one-cycle tick every DIV clk cycles.
module tick_gen #(
  parameter int unsigned DIV = 1300000
) (
  input  logic clk,
  input  logic rst,
  output logic tick_o
);
  localparam int unsigned W = DIV > 1 ? $clog2(DIV) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  assign tick_o = cnt_q == W'(DIV - 1);
  assign cnt_d = tick_o ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/turn_ctl.sv
// turn_ctl: turn scheduler, force charging, damage and winner for the throw units.
// TURN_CTL_WIND_RANDOM_EN selects LFSR-driven wind per turn; otherwise wind is calm.
module turn_ctl
  import throw_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 1300000,
  parameter int unsigned FORCE_MAX    = 1000,
  parameter int unsigned FORCE_STEP   = 10,
  parameter int unsigned FLIGHT_TICKS = 120,
  parameter int unsigned GAP_CYCLES   = 4,
  parameter int unsigned HP_MAX       = 100,
  parameter int unsigned DAMAGE       = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       btn_left,
  input  logic       hit_cat,
  input  logic       hit_dog,
  output logic       enable_cat,
  output logic       enable_dog,
  output logic [9:0] throw_force,
  output logic [6:0] wind,
  output logic       turn,
  output logic [6:0] hp_cat,
  output logic [6:0] hp_dog,
  output logic       game_over,
  output logic       winner
);
  localparam int unsigned TW = $clog2(FLIGHT_TICKS + 1);
  localparam int unsigned GW = $clog2(GAP_CYCLES + 1);
  turn_state_t state_q, state_d;
  logic [9:0] force_q, force_d;
  logic [6:0] hp_cat_q, hp_cat_d, hp_dog_q, hp_dog_d;
  logic turn_q, turn_d, winner_q, winner_d, hit_q, hit_d, btn_q;
  logic [TW-1:0] timer_q, timer_d;
  logic [GW-1:0] gap_q, gap_d;
  logic tick, press, valid_hit, timeout, gap_done, hp_zero;
  logic [10:0] force_sum;
  logic [9:0] force_sat;
  tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .tick_o(tick)
  );
  assign press = btn_left & ~btn_q;
  // only the opponent's target counts; self-hits are dropped here
  assign valid_hit = turn_q == PLAYER_CAT ? hit_dog : hit_cat;
  assign timeout = tick && timer_q == TW'(FLIGHT_TICKS - 1);
  assign gap_done = gap_q == GW'(GAP_CYCLES - 1);
  assign hp_zero = hp_cat_q == 7'd0 || hp_dog_q == 7'd0;
  assign force_sum = {1'b0, force_q} + 11'(FORCE_STEP);
  assign force_sat = force_sum > 11'(FORCE_MAX) ? 10'(FORCE_MAX) : force_sum[9:0];
  always_comb begin
    state_d = state_q;
    force_d = force_q;
    hp_cat_d = hp_cat_q;
    hp_dog_d = hp_dog_q;
    turn_d = turn_q;
    winner_d = winner_q;
    hit_d = hit_q;
    timer_d = timer_q;
    gap_d = gap_q;
    case (state_q)
      ST_IDLE, ST_OVER: if (start) begin
        hp_cat_d = 7'(HP_MAX);
        hp_dog_d = 7'(HP_MAX);
        turn_d = PLAYER_CAT;
        force_d = '0;
        state_d = ST_AIM;
      end
      ST_AIM: begin
        force_d = '0;
        if (press) state_d = ST_CHARGE;
      end
      ST_CHARGE: begin
        timer_d = '0;
        if (!btn_left) state_d = ST_FLIGHT;
        else if (tick) force_d = force_sat;
      end
      ST_FLIGHT: begin
        if (tick) timer_d = timer_q + 1'b1;
        if (valid_hit || timeout) begin
          hit_d = valid_hit;
          state_d = ST_RESOLVE;
        end
      end
      ST_RESOLVE: begin
        if (hit_q && turn_q == PLAYER_CAT) hp_dog_d = sat_sub(hp_dog_q, 7'(DAMAGE));
        if (hit_q && turn_q == PLAYER_DOG) hp_cat_d = sat_sub(hp_cat_q, 7'(DAMAGE));
        hit_d = 1'b0;
        gap_d = '0;
        state_d = ST_GAP;
      end
      ST_GAP: begin
        gap_d = gap_q + 1'b1;
        if (gap_done && hp_zero) begin
          winner_d = turn_q;
          state_d = ST_OVER;
        end else if (gap_done) begin
          turn_d = ~turn_q;
          force_d = '0;
          state_d = ST_AIM;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      force_q <= '0;
      hp_cat_q <= 7'(HP_MAX);
      hp_dog_q <= 7'(HP_MAX);
      turn_q <= PLAYER_CAT;
      winner_q <= 1'b0;
      hit_q <= 1'b0;
      timer_q <= '0;
      gap_q <= '0;
      btn_q <= 1'b0;
    end else begin
      state_q <= state_d;
      force_q <= force_d;
      hp_cat_q <= hp_cat_d;
      hp_dog_q <= hp_dog_d;
      turn_q <= turn_d;
      winner_q <= winner_d;
      hit_q <= hit_d;
      timer_q <= timer_d;
      gap_q <= gap_d;
      btn_q <= btn_left;
    end
  end
`ifdef TURN_CTL_WIND_RANDOM_EN
  logic [15:0] lfsr_q;
  logic [6:0] wind_q;
  logic switch_turn;
  assign switch_turn = state_q == ST_GAP && gap_done && !hp_zero;
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= 16'hACE1;
      wind_q <= WIND_CALM;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      if (switch_turn) wind_q <= wind_mod101(lfsr_q[6:0]);
    end
  end
  assign wind = wind_q;
`else
  assign wind = WIND_CALM;
`endif
  assign enable_cat = state_q == ST_FLIGHT && turn_q == PLAYER_CAT;
  assign enable_dog = state_q == ST_FLIGHT && turn_q == PLAYER_DOG;
  assign throw_force = force_q;
  assign turn = turn_q;
  assign hp_cat = hp_cat_q;
  assign hp_dog = hp_dog_q;
  assign game_over = state_q == ST_OVER;
  assign winner = winner_q;
endmodule

// File: tb/tb_turn_ctl.sv
// tb_turn_ctl: directed scenario bench for turn_ctl with a fast tick (TICK_DIV=4).
module tb_turn_ctl;
  import throw_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, btn_left = 1'b0, hit_cat = 1'b0, hit_dog = 1'b0;
  logic enable_cat, enable_dog, turn, game_over, winner;
  logic [9:0] throw_force;
  logic [6:0] wind, hp_cat, hp_dog;
  int checks = 0, errors = 0, wind_bad = 0, wind_changes = 0;
  turn_state_t prev_state;
  logic [6:0] prev_wind;
  bit prev_ok = 1'b0;

  always #5 clk = ~clk;

  turn_ctl #(
    .TICK_DIV(4), .FORCE_MAX(1000), .FORCE_STEP(10), .FLIGHT_TICKS(8),
    .GAP_CYCLES(4), .HP_MAX(100), .DAMAGE(20)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .btn_left(btn_left),
    .hit_cat(hit_cat), .hit_dog(hit_dog), .enable_cat(enable_cat),
    .enable_dog(enable_dog), .throw_force(throw_force), .wind(wind),
    .turn(turn), .hp_cat(hp_cat), .hp_dog(hp_dog), .game_over(game_over),
    .winner(winner)
  );

  // wind may only move on the GAP->AIM turn switch and must stay in range
  always @(negedge clk) begin
    if (rst) prev_ok <= 1'b0;
    else begin
      if (prev_ok && wind !== prev_wind) begin
        wind_changes <= wind_changes + 1;
        if (!(prev_state == ST_GAP && dut.state_q == ST_AIM)) wind_bad <= wind_bad + 1;
      end
`ifdef TURN_CTL_WIND_RANDOM_EN
      if (wind > 7'd100) wind_bad <= wind_bad + 1;
`else
      if (wind !== 7'd50) wind_bad <= wind_bad + 1;
`endif
      prev_ok <= 1'b1;
      prev_wind <= wind;
      prev_state <= dut.state_q;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input turn_state_t s, input int budget, input string tag);
    int n = 0;
    while (dut.state_q !== s && n < budget) begin
      step(1);
      n++;
    end
    checks++;
    if (dut.state_q !== s) begin
      errors++;
      $display("FAIL %s: state %0d, expected %0d within %0d cycles", tag, dut.state_q, s, budget);
    end
  endtask

  task automatic throw_hold(input int n);
    btn_left = 1'b1;
    step(n + 1);
    btn_left = 1'b0;
    step(1);
  endtask

  task automatic cat_hit_turn();
    throw_hold(4);
    hit_dog = 1'b1;
    step(1);
    hit_dog = 1'b0;
    step(1);
  endtask

  task automatic dog_timeout_turn();
    throw_hold(4);
    wait_state(ST_AIM, 60, "dog_timeout_to_aim");
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    step(1);
    checks++;
    if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dut.state_q, ST_IDLE); end
    checks++;
    if (hp_cat !== 7'd100 || hp_dog !== 7'd100) begin errors++; $display("FAIL reset_hp: got %0d/%0d expected 100/100", hp_cat, hp_dog); end
    checks++;
    if ({enable_cat, enable_dog, turn, game_over, winner} !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b expected 00000", {enable_cat, enable_dog, turn, game_over, winner}); end
    checks++;
    if (throw_force !== 10'd0 || wind !== 7'd50) begin errors++; $display("FAIL reset_force_wind: got %0d/%0d expected 0/50", throw_force, wind); end
  endtask

  task automatic test_charge();
    start = 1'b1;
    step(1);
    start = 1'b0;
    checks++;
    if (dut.state_q !== ST_AIM || throw_force !== 10'd0) begin errors++; $display("FAIL start_to_aim: state %0d force %0d expected %0d/0", dut.state_q, throw_force, ST_AIM); end
    throw_hold(40);
    checks++;
    if (enable_cat !== 1'b1 || enable_dog !== 1'b0) begin errors++; $display("FAIL cat_enable: got %b%b expected 10", enable_cat, enable_dog); end
    checks++;
    if (throw_force !== 10'd100) begin errors++; $display("FAIL charge_force: got %0d expected 100", throw_force); end
    step(2);
    checks++;
    if (throw_force !== 10'd100) begin errors++; $display("FAIL force_frozen: got %0d expected 100", throw_force); end
  endtask

  task automatic test_hit();
    hit_dog = 1'b1;
    step(1);
    hit_dog = 1'b0;
    checks++;
    if (enable_cat !== 1'b0) begin errors++; $display("FAIL hit_enable_drop: got %b expected 0", enable_cat); end
    step(1);
    checks++;
    if (hp_dog !== 7'd80 || hp_cat !== 7'd100) begin errors++; $display("FAIL hit_damage: got cat %0d dog %0d expected 100/80", hp_cat, hp_dog); end
    step(3);
    checks++;
    if (dut.state_q !== ST_GAP || turn !== 1'b0) begin errors++; $display("FAIL gap_len: state %0d turn %b expected %0d/0", dut.state_q, turn, ST_GAP); end
    step(1);
    checks++;
    if (dut.state_q !== ST_AIM || turn !== 1'b1) begin errors++; $display("FAIL turn_switch: state %0d turn %b expected %0d/1", dut.state_q, turn, ST_AIM); end
  endtask

  task automatic test_self_hit();
    int n = 0;
    throw_hold(4);
    checks++;
    if (enable_dog !== 1'b1 || enable_cat !== 1'b0) begin errors++; $display("FAIL dog_enable: got cat %b dog %b expected 0/1", enable_cat, enable_dog); end
    hit_dog = 1'b1;
    step(1);
    hit_dog = 1'b0;
    n = 1;
    checks++;
    if (enable_dog !== 1'b1) begin errors++; $display("FAIL self_hit_ignored: enable_dog %b expected 1", enable_dog); end
    while (enable_dog === 1'b1 && n < 50) begin
      step(1);
      n++;
    end
    checks++;
    if (n < 29 || n > 32) begin errors++; $display("FAIL flight_timeout: flight lasted %0d cycles, expected 29..32", n); end
    step(1);
    checks++;
    if (hp_cat !== 7'd100 || hp_dog !== 7'd80) begin errors++; $display("FAIL timeout_no_damage: got cat %0d dog %0d expected 100/80", hp_cat, hp_dog); end
    wait_state(ST_AIM, 10, "self_hit_to_aim");
    checks++;
    if (turn !== 1'b0) begin errors++; $display("FAIL turn_back_cat: got %b expected 0", turn); end
  endtask

  task automatic test_saturate();
    throw_hold(600);
    checks++;
    if (throw_force !== 10'd1000) begin errors++; $display("FAIL force_saturate: got %0d expected 1000", throw_force); end
    hit_dog = 1'b1;
    step(1);
    hit_dog = 1'b0;
    wait_state(ST_AIM, 10, "saturate_to_aim");
    checks++;
    if (hp_dog !== 7'd60 || turn !== 1'b1) begin errors++; $display("FAIL saturate_hit: hp_dog %0d turn %b expected 60/1", hp_dog, turn); end
  endtask

  task automatic test_game_over();
    for (int i = 0; i < 3; i++) begin
      dog_timeout_turn();
      cat_hit_turn();
      if (i < 2) wait_state(ST_AIM, 10, "cat_hit_to_aim");
    end
    checks++;
    if (hp_dog !== 7'd0 || hp_cat !== 7'd100) begin errors++; $display("FAIL final_hp: got cat %0d dog %0d expected 100/0", hp_cat, hp_dog); end
    step(3);
    checks++;
    if (game_over !== 1'b0) begin errors++; $display("FAIL over_early: game_over %b expected 0", game_over); end
    step(1);
    checks++;
    if (game_over !== 1'b1 || winner !== 1'b0 || dut.state_q !== ST_OVER) begin errors++; $display("FAIL game_over: over %b winner %b state %0d expected 1/0/%0d", game_over, winner, dut.state_q, ST_OVER); end
    btn_left = 1'b1;
    hit_cat = 1'b1;
    step(1);
    hit_cat = 1'b0;
    step(3);
    btn_left = 1'b0;
    step(3);
    checks++;
    if (dut.state_q !== ST_OVER || {enable_cat, enable_dog} !== 2'b00 || hp_cat !== 7'd100 || hp_dog !== 7'd0) begin errors++; $display("FAIL over_frozen: state %0d en %b%b hp %0d/%0d expected %0d 00 100/0", dut.state_q, enable_cat, enable_dog, hp_cat, hp_dog, ST_OVER); end
    start = 1'b1;
    step(1);
    start = 1'b0;
    checks++;
    if (hp_cat !== 7'd100 || hp_dog !== 7'd100 || turn !== 1'b0 || game_over !== 1'b0 || dut.state_q !== ST_AIM) begin errors++; $display("FAIL restart: hp %0d/%0d turn %b over %b state %0d expected 100/100 0 0 %0d", hp_cat, hp_dog, turn, game_over, dut.state_q, ST_AIM); end
  endtask

  task automatic test_rst_mid_flight();
    cat_hit_turn();
    wait_state(ST_AIM, 10, "rst_setup_cat");
    dog_timeout_turn();
    throw_hold(8);
    start = 1'b1;
    step(1);
    start = 1'b0;
    checks++;
    if (dut.state_q !== ST_FLIGHT || hp_dog !== 7'd80 || enable_cat !== 1'b1 || throw_force !== 10'd20) begin errors++; $display("FAIL start_in_flight: state %0d hp_dog %0d en %b force %0d expected %0d 80 1 20", dut.state_q, hp_dog, enable_cat, throw_force, ST_FLIGHT); end
    rst = 1'b1;
    step(1);
    checks++;
    if ({enable_cat, enable_dog} !== 2'b00 || throw_force !== 10'd0) begin errors++; $display("FAIL rst_outputs: en %b%b force %0d expected 00/0", enable_cat, enable_dog, throw_force); end
    checks++;
    if (hp_cat !== 7'd100 || hp_dog !== 7'd100 || dut.state_q !== ST_IDLE || turn !== 1'b0) begin errors++; $display("FAIL rst_state: hp %0d/%0d state %0d turn %b expected 100/100 %0d 0", hp_cat, hp_dog, dut.state_q, turn, ST_IDLE); end
    rst = 1'b0;
    step(1);
  endtask

  task automatic test_wind();
    start = 1'b1;
    step(1);
    start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      throw_hold(2);
      wait_state(ST_AIM, 60, "wind_turn");
    end
    checks++;
    if (wind_bad !== 0) begin errors++; $display("FAIL wind_monitor: %0d bad samples, expected 0", wind_bad); end
`ifdef TURN_CTL_WIND_RANDOM_EN
    checks++;
    if (wind_changes == 0 || wind > 7'd100) begin errors++; $display("FAIL wind_random: %0d changes, wind %0d, expected changes and wind<=100", wind_changes, wind); end
`else
    checks++;
    if (wind !== 7'd50 || wind_changes !== 0) begin errors++; $display("FAIL wind_calm: wind %0d changes %0d expected 50/0", wind, wind_changes); end
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_charge();
    test_hit();
    test_self_hit();
    test_saturate();
    test_game_over();
    test_rst_mid_flight();
    test_wind();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/turn_ctl.md
Name: turn_ctl

Overview:
- Round/turn scheduler for the cat-vs-dog throw datapath.
- Alternates turns between the cat and dog throw units and charges throw force while the mouse button is held.
- Gates each unit's enable for exactly one flight, counts hits as damage and declares the winner.
- Sits between mouse/button input logic and the throw_ctl units; its HP, turn and force outputs feed the HUD drawing blocks.

Parameters:
- TICK_DIV, 1300000: clk cycles per game tick (force ramp and flight timer step).
- FORCE_MAX, 1000: saturation value of throw_force; must fit 10 bits.
- FORCE_STEP, 10: throw_force increment per tick while charging.
- FLIGHT_TICKS, 120: game ticks after which a flight with no hit is ended.
- GAP_CYCLES, 4: clk cycles with both enables low between consecutive flights; minimum 2.
- HP_MAX, 100: starting HP per player; must fit 7 bits.
- DAMAGE, 20: HP removed per valid hit.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  level; starts or restarts a game from ST_IDLE or ST_OVER
- btn_left  in  1  mouse left button level, already synchronised
- hit_cat  in  1  one-cycle pulse: the cat target was struck
- hit_dog  in  1  one-cycle pulse: the dog target was struck
- enable_cat  out  1  enable for the cat throw unit
- enable_dog  out  1  enable for the dog throw unit
- throw_force  out  10  charged force; held constant during flight
- wind  out  7  wind value 0..100; 50 means calm
- turn  out  1  0 = cat throws, 1 = dog throws
- hp_cat  out  7  cat HP
- hp_dog  out  7  dog HP
- game_over  out  1  high while in ST_OVER
- winner  out  1  0 = cat, 1 = dog; valid only while game_over = 1

Behaviour:
- Reset values: state ST_IDLE; hp_cat = hp_dog = HP_MAX; throw_force 0; both enables 0; turn 0; game_over 0; winner 0; wind 50; tick prescaler 0.
- Tick: free-running prescaler, one-cycle pulse when the count reaches TICK_DIV-1, then wraps to 0. The prescaler is cleared only by rst.
- Button press detection: rising edge of btn_left, using a registered copy.
- States: ST_IDLE, ST_AIM, ST_CHARGE, ST_FLIGHT, ST_RESOLVE, ST_GAP, ST_OVER.
- ST_IDLE: on start=1, load both HPs to HP_MAX, set turn=0, go to ST_AIM.
- ST_AIM: throw_force = 0. On a btn_left rising edge, go to ST_CHARGE.
  - A button already held on entry to ST_AIM is ignored until it is released and pressed again.
- ST_CHARGE: each tick, throw_force = min(throw_force + FORCE_STEP, FORCE_MAX).
  - On btn_left = 0, go to ST_FLIGHT.
  - throw_force freezes on the release cycle.
  - The flight timer clears.
- ST_FLIGHT:
  - Enable of the current player is 1: enable_cat when turn=0, enable_dog when turn=1. The other enable is 0.
  - The flight timer increments per tick.
  - Valid hit = opponent target pulse only: hit_dog when turn=0, hit_cat when turn=1. Self-hits are ignored.
  - A valid hit latches a hit flag and goes to ST_RESOLVE next cycle.
  - Timer reaching FLIGHT_TICKS goes to ST_RESOLVE with no hit.
  - Hit and timeout on the same cycle count as a hit.
- ST_RESOLVE (1 cycle): both enables 0.
  - If the hit flag is set, the opponent loses DAMAGE HP, saturating at 0.
  - Clear the hit flag, go to ST_GAP.
- ST_GAP: enables stay 0 for GAP_CYCLES cycles; this lets the throw units return to idle. Then:
  - If either HP is 0: go to ST_OVER with winner = turn, i.e. the last thrower.
  - Otherwise: toggle turn, update wind, go to ST_AIM.
- ST_OVER: game_over = 1; outputs frozen. start=1 restarts as from ST_IDLE.
- Hit pulses outside ST_FLIGHT are ignored.
- At most one hit is counted per flight.
- start outside ST_IDLE and ST_OVER is ignored.
- rst in any state, including mid-flight, restores the reset values on the next edge. Enables drop immediately.

Optional Feature:
- Macro: TURN_CTL_WIND_RANDOM_EN.
- Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1 on rst) steps every clk.
  - At each turn switch, wind = lfsr[6:0] mod 101.
- Undefined: wind is constant 50. No LFSR logic is synthesised.

Decomposition:
- Shared package throw_pkg: state enum turn_state_t; constants PLAYER_CAT=0 and PLAYER_DOG=1; WIND_CALM=50.
- Sub-module tick_gen (prescaler producing a one-cycle tick).
  - Reusable by the throw units, replacing their private ms counters.

Test Plan:
- Parameters for the bench: TICK_DIV=4, FORCE_STEP=10, FLIGHT_TICKS=8, GAP_CYCLES=4.
- rst, then start; press btn_left, hold 40 clk, release -> throw_force=100 frozen; enable_cat=1 next cycle, enable_dog=0.
- During cat flight pulse hit_dog -> enable_cat falls within 2 cycles; hp_dog=80; after 4 gap cycles turn=1, state ST_AIM.
- During dog flight pulse hit_dog (self-hit), no hit_cat -> timeout after 8 ticks; hp_cat and hp_dog unchanged; turn returns to 0.
- Hold button 600 clk -> throw_force saturates at 1000, never wraps.
- Five valid cat hits -> hp_dog=0, game_over=1, winner=0; further button presses ignored. start -> HPs 100, turn=0, game_over=0.
- Assert rst mid-flight -> next cycle enables 0, throw_force 0, HPs 100, state ST_IDLE.
- Optional feature, TURN_CTL_WIND_RANDOM_EN defined: wind stays ≤100 over 50 turns and changes only at turn switches.
- Optional feature, macro undefined: wind stays 50.
